fifo_bram_thresh: RTL and testbench
===================================

FIFO_BRAM_THRESH -- requirements
Module: fifo_bram_thresh

Interface
REQ-001 SHALL have parameter MEM_STYLE, default "auto": RAM inference style attribute.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: entry width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5: RAM address width.
REQ-004 SHALL have parameter DEPTH, default 32: RAM entries, 2 <= DEPTH <= 2**ADDR_WIDTH, any value (not only powers of two).
REQ-005 SHALL have parameter GRACE_PERIOD, default 2: writes still accepted after if_full_n falls, 0 <= GRACE_PERIOD < DEPTH.
REQ-006 SHALL have parameter AE_THRESHOLD, default 2: almost-empty level, 0 < AE_THRESHOLD < DEPTH.
REQ-007 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port if_full_n, output, 1: low when almost full.
REQ-010 SHALL have ports if_write_ce and if_write, input, 1 each: write enable pair.
REQ-011 SHALL have port if_din, input, DATA_WIDTH: write data.
REQ-012 SHALL have port if_empty_n, output, 1: if_dout valid (FWFT).
REQ-013 SHALL have ports if_read_ce and if_read, input, 1 each: read enable pair.
REQ-014 SHALL have port if_dout, output, DATA_WIDTH: head data.
REQ-015 SHALL have port if_almost_empty_n, output, 1: low when level <= AE_THRESHOLD.
REQ-016 SHALL have port if_level, output, ADDR_WIDTH+1: total entries held (RAM + output register).

Function
REQ-017 SHALL keep used (ADDR_WIDTH+1 bits) = entries in RAM; level = used + dout_valid.
REQ-018 SHALL push when if_write_ce & if_write & (used < DEPTH); writes at used == DEPTH are dropped, with no state change.
REQ-019 SHALL drive if_full_n = (used < DEPTH - GRACE_PERIOD), combinational from registered used.
REQ-020 SHALL pop (RAM to output register) when used != 0 & if_read_ce & (~dout_valid | if_read).
REQ-021 SHALL wrap waddr/raddr from DEPTH-1 to 0; simultaneous push and pop leave used unchanged.
REQ-022 SHALL give a write-to-if_empty_n latency of 2 cycles into an empty FIFO: push at cycle t, if_empty_n=1 with that data at t+2.
REQ-023 SHALL bypass RAM read latency: if the entry pushed at t-1 is the only RAM entry, a pop at t takes it from the captured write data, not the RAM.
REQ-024 SHALL hold if_dout stable while if_empty_n=1 and no read occurs.
REQ-025 SHALL clear dout_valid on if_read_ce & if_read without a pop.
REQ-026 SHALL preserve FIFO order across all push/pop/wrap combinations.
REQ-027 SHALL drive if_level and if_almost_empty_n from registers only, updated the cycle after the causing event.

Reset
REQ-028 SHALL, on reset, set waddr=raddr=used=0, dout_valid=0, if_dout=0, if_level=0.
REQ-029 SHALL, on reset, drive if_full_n=1, if_empty_n=0, if_almost_empty_n=0.
REQ-030 SHALL, on reset mid-operation, discard all contents; RAM contents are not cleared.

Configuration
REQ-031 SHALL, with FIFO_BRAM_THRESH_ERR_EN defined, add outputs if_overflow and if_underflow (1 bit each).
REQ-032 SHALL, with the macro defined, set if_overflow sticky on a write attempt at used == DEPTH.
REQ-033 SHALL, with the macro defined, set if_underflow sticky on if_read_ce & if_read with if_empty_n=0.
REQ-034 SHALL, with the macro defined, clear both flags only on reset.
REQ-035 SHALL, without the macro, omit both ports and their logic.

Verification
REQ-036 SHALL cover: reset, one write of 0xA5 -> if_empty_n=1 and if_dout=0xA5 exactly 2 cycles later; if_level=1.
REQ-037 SHALL cover: DEPTH=32, GRACE_PERIOD=2, continuous writes, no reads -> if_full_n falls when used=30; 32 writes accepted; 33rd dropped (if_overflow=1 with macro).
REQ-038 SHALL cover: fill 0..31, then read all -> data 0..31 in order; if_almost_empty_n falls when level reaches 2.
REQ-039 SHALL cover: DEPTH=5, 100 concurrent random read/write cycles -> order preserved through wrap; if_level matches scoreboard every cycle.
REQ-040 SHALL cover: reset asserted with 10 entries held -> next cycle if_empty_n=0, if_level=0, if_full_n=1.
REQ-041 SHALL cover: read on empty FIFO -> no state change; if_underflow=1 with macro, port absent without it.

Source files
------------

// File: rtl/fifo_bram_thresh.sv
// First-word-fall-through FIFO on a synchronous-read RAM with a prefetch output register,
// a grace-period full flag and a registered level/almost-empty. Define FIFO_BRAM_THRESH_ERR_EN for sticky error flags.
module fifo_bram_thresh #(
    parameter string MEM_STYLE    = "auto",
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 5,
    parameter int    DEPTH        = 32,
    parameter int    GRACE_PERIOD = 2,
    parameter int    AE_THRESHOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_almost_empty_n,
    output logic [ADDR_WIDTH:0]   if_level
`ifdef FIFO_BRAM_THRESH_ERR_EN
    ,
    output logic                  if_overflow,
    output logic                  if_underflow
`endif
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   FULL_C    = (ADDR_WIDTH+1)'(DEPTH - GRACE_PERIOD);
    localparam logic [ADDR_WIDTH:0]   AE_C      = (ADDR_WIDTH+1)'(AE_THRESHOLD);
    localparam logic [ADDR_WIDTH:0]   ONE_C     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH) || GRACE_PERIOD < 0 || GRACE_PERIOD >= DEPTH ||
        AE_THRESHOLD <= 0 || AE_THRESHOLD >= DEPTH || MEM_STYLE == "") begin : g_param_check
        $error("fifo_bram_thresh: illegal parameter combination");
    end

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    (* ram_style = MEM_STYLE *)
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] waddr, raddr, raddr_nxt, waddr_q;
    logic [ADDR_WIDTH:0]   used, used_nxt, level_nxt;
    logic [DATA_WIDTH-1:0] ram_q, wdata_q;
    logic                  dout_valid, dout_valid_nxt, push_q;
    logic                  push, pop, consume, bypass;

    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        push           = if_write_ce & if_write & (used < DEPTH_C);
        pop            = (used != '0) & if_read_ce & (~dout_valid | if_read);
        consume        = if_read_ce & if_read & dout_valid;
        raddr_nxt      = raddr;
        used_nxt       = used;
        dout_valid_nxt = dout_valid;
        if (pop) begin
            raddr_nxt = next_addr(raddr);
        end
        unique case ({push, pop})
            2'b10:   used_nxt = used + ONE_C;
            2'b01:   used_nxt = used - ONE_C;
            default: used_nxt = used;
        endcase
        if (pop) begin
            dout_valid_nxt = 1'b1;
        end else if (consume) begin
            dout_valid_nxt = 1'b0;
        end
        level_nxt = used_nxt + (ADDR_WIDTH+1)'(dout_valid_nxt);
    end

    // The head was written on the previous edge, so the RAM read issued then returned stale data.
    assign bypass = push_q & (waddr_q == raddr);

    // NOTE: RAM array and its read register carry no reset, which lets them map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[waddr] <= if_din;
        end
        ram_q   <= mem[raddr_nxt];
        waddr_q <= waddr;
        wdata_q <= if_din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr             <= '0;
            raddr             <= '0;
            used              <= '0;
            dout_valid        <= 1'b0;
            if_dout           <= '0;
            if_level          <= '0;
            if_almost_empty_n <= 1'b0;
            push_q            <= 1'b0;
        end else begin
            if (push) begin
                waddr <= next_addr(waddr);
            end
            raddr             <= raddr_nxt;
            used              <= used_nxt;
            dout_valid        <= dout_valid_nxt;
            push_q            <= push;
            if_level          <= level_nxt;
            if_almost_empty_n <= (level_nxt > AE_C);
            if (pop) begin
                if_dout <= bypass ? wdata_q : ram_q;
            end
        end
    end

    assign if_full_n  = (used < FULL_C);
    assign if_empty_n = dout_valid;

`ifdef FIFO_BRAM_THRESH_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if_overflow  <= 1'b0;
            if_underflow <= 1'b0;
        end else begin
            if (if_write_ce & if_write & (used == DEPTH_C)) begin
                if_overflow <= 1'b1;
            end
            if (if_read_ce & if_read & ~dout_valid) begin
                if_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_bram_thresh.sv
// Self-checking bench for fifo_bram_thresh: directed vector table, fill/drain, reset and a DEPTH=5 wrap run.
module tb_fifo_bram_thresh;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 32;
    localparam int AW5    = 3;
    localparam int DEPTH5 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          wce, wr, rce, rd;
    logic [DW-1:0] din, dout;
    logic          full_n, empty_n, ae_n;
    logic [AW:0]   level;

    logic          b_wce, b_wr, b_rce, b_rd;
    logic [DW-1:0] b_din, b_dout;
    logic          b_full_n, b_empty_n, b_ae_n;
    logic [AW5:0]  b_level;
`ifdef FIFO_BRAM_THRESH_ERR_EN
    logic ovf, unf, b_ovf, b_unf;
`endif

    fifo_bram_thresh #(
        .MEM_STYLE("auto"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .GRACE_PERIOD(2), .AE_THRESHOLD(2)
    ) u_dut (
        .clk(clk), .reset(reset), .if_full_n(full_n),
        .if_write_ce(wce), .if_write(wr), .if_din(din),
        .if_empty_n(empty_n), .if_read_ce(rce), .if_read(rd), .if_dout(dout),
        .if_almost_empty_n(ae_n), .if_level(level)
`ifdef FIFO_BRAM_THRESH_ERR_EN
        , .if_overflow(ovf), .if_underflow(unf)
`endif
    );

    fifo_bram_thresh #(
        .MEM_STYLE("auto"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW5), .DEPTH(DEPTH5),
        .GRACE_PERIOD(1), .AE_THRESHOLD(2)
    ) u_dut5 (
        .clk(clk), .reset(reset), .if_full_n(b_full_n),
        .if_write_ce(b_wce), .if_write(b_wr), .if_din(b_din),
        .if_empty_n(b_empty_n), .if_read_ce(b_rce), .if_read(b_rd), .if_dout(b_dout),
        .if_almost_empty_n(b_ae_n), .if_level(b_level)
`ifdef FIFO_BRAM_THRESH_ERR_EN
        , .if_overflow(b_ovf), .if_underflow(b_unf)
`endif
    );

    typedef struct {
        logic          wce, wr, rce, rd;
        logic [DW-1:0] din;
        logic          e_empty_n;
        logic [DW-1:0] e_dout;
        logic [AW:0]   e_level;
        logic          e_full_n, e_ae_n;
    } vec_t;

    vec_t vecs[15];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] mq[$];
        logic          m_valid;
        logic [DW-1:0] m_dout;
        logic          m_push, m_pop, m_cons;
        int            exp_used;

        // wce wr rce rd din | empty_n dout level full_n ae_n
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 6'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hA5, 1'b0, 32'h00, 6'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'hA5, 6'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 1'b1, 32'hA5, 6'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 1'b1, 32'hA5, 6'd3, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h11, 6'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 32'h22, 6'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h33, 6'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h33, 6'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h33, 6'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 32'h33, 6'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h44, 6'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h44, 6'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h44, 6'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 1'b0, 32'h44, 6'd0, 1'b1, 1'b0};

        {wce, wr, rce, rd, din} = '0;
        {b_wce, b_wr, b_rce, b_rd, b_din} = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("reset_empty_n", empty_n, 0);
        check("reset_level", level, 0);
        check("reset_full_n", full_n, 1);
        check("reset_ae_n", ae_n, 0);
        check("reset_dout", dout, 0);

        for (int i = 0; i < 15; i++) begin
            {wce, wr, rce, rd} = {vecs[i].wce, vecs[i].wr, vecs[i].rce, vecs[i].rd};
            din = vecs[i].din;
            tick();
            check($sformatf("vec%0d_empty_n", i), empty_n, vecs[i].e_empty_n);
            check($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
            check($sformatf("vec%0d_level", i), level, vecs[i].e_level);
            check($sformatf("vec%0d_full_n", i), full_n, vecs[i].e_full_n);
            check($sformatf("vec%0d_ae_n", i), ae_n, vecs[i].e_ae_n);
        end
`ifdef FIFO_BRAM_THRESH_ERR_EN
        check("underflow_after_empty_read", unf, 1);
        check("no_overflow_yet", ovf, 0);
`endif
        {wce, wr, rce, rd} = '0;

        // Fill with no reads: full_n drops at 30 entries, the 33rd write is dropped.
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            exp_used = (i + 1 > DEPTH) ? DEPTH : i + 1;
            wce = 1'b1;
            wr  = 1'b1;
            din = DW'(i);
            tick();
            check($sformatf("fill%0d_full_n", i), full_n, (exp_used < DEPTH - 2));
            check($sformatf("fill%0d_level", i), level, exp_used);
        end
`ifdef FIFO_BRAM_THRESH_ERR_EN
        check("overflow_sticky", ovf, 1);
`endif
        wce = 1'b0;
        wr  = 1'b0;

        // Drain in order; almost-empty falls once the level reaches 2.
        rce = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d_empty_n", i), empty_n, 1);
            check($sformatf("drain%0d_dout", i), dout, i);
            check($sformatf("drain%0d_level", i), level, DEPTH - i);
            check($sformatf("drain%0d_ae_n", i), ae_n, (DEPTH - i) > 2);
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        check("drained_empty_n", empty_n, 0);
        check("drained_level", level, 0);

        // Reset with ten entries held discards everything.
        for (int i = 0; i < 10; i++) begin
            wce = 1'b1;
            wr  = 1'b1;
            din = DW'(32'h100 + i);
            tick();
        end
        wce = 1'b0;
        wr  = 1'b0;
        tick();
        check("held10_level", level, 10);
        check("held10_ae_n", ae_n, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_empty_n", empty_n, 0);
        check("midreset_level", level, 0);
        check("midreset_full_n", full_n, 1);
        check("midreset_ae_n", ae_n, 0);
`ifdef FIFO_BRAM_THRESH_ERR_EN
        check("midreset_overflow", ovf, 0);
        check("midreset_underflow", unf, 0);
`endif
        wce = 1'b1;
        wr  = 1'b1;
        din = 32'h77;
        tick();
        wce = 1'b0;
        wr  = 1'b0;
        tick();
        check("post_reset_dout", dout, 32'h77);
        check("post_reset_level", level, 1);
        rce = 1'b0;

        // DEPTH=5: random concurrent traffic against a queue model, wrapping many times.
        m_valid = 1'b0;
        m_dout  = '0;
        for (int c = 0; c < 100; c++) begin
            b_wce = ($urandom_range(0, 7) != 0);
            b_wr  = ($urandom_range(0, 1) == 1);
            b_rce = ($urandom_range(0, 7) != 0);
            b_rd  = ($urandom_range(0, 1) == 1);
            b_din = $urandom;
            m_push = b_wce & b_wr & (mq.size() < DEPTH5);
            m_pop  = (mq.size() != 0) & b_rce & (~m_valid | b_rd);
            m_cons = b_rce & b_rd & m_valid;
            if (m_pop) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end else if (m_cons) begin
                m_valid = 1'b0;
            end
            if (m_push) begin
                mq.push_back(b_din);
            end
            tick();
            check($sformatf("d5_c%0d_empty_n", c), b_empty_n, m_valid);
            check($sformatf("d5_c%0d_level", c), b_level, mq.size() + int'(m_valid));
            check($sformatf("d5_c%0d_full_n", c), b_full_n, mq.size() < DEPTH5 - 1);
            check($sformatf("d5_c%0d_ae_n", c), b_ae_n, (mq.size() + int'(m_valid)) > 2);
            if (m_valid) begin
                check($sformatf("d5_c%0d_dout", c), b_dout, m_dout);
            end
        end
        {b_wce, b_wr, b_rce, b_rd} = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
